// File: rtl/aes_mixcolumns_seq.sv
// Forward AES MixColumns, column-serial with valid/ready handshake on both sides.
// Optional feature: define AES_MIXCOL_BYPASS_EN to add in_bypass (final-round pass-through).
module aes_mixcolumns_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
`ifdef AES_MIXCOL_BYPASS_EN
    input  logic         in_bypass,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("aes_mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Column groups are aligned, so masking the low index bits selects the active group.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] GRP_MASK = ~2'(COLS_PER_CYCLE - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_idx_q, col_idx_d;
    logic [127:0] work_q, work_d;
    logic [127:0] acc_q, acc_d;
    logic [127:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;
    logic         accept;
`ifdef AES_MIXCOL_BYPASS_EN
    logic         bypass_q, bypass_d;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a, b, c, d;
        a = col[31:24];
        b = col[23:16];
        c = col[15:8];
        d = col[7:0];
        return {xtime(a) ^ xtime(b) ^ b ^ c ^ d,
                a ^ xtime(b) ^ xtime(c) ^ c ^ d,
                a ^ b ^ xtime(c) ^ xtime(d) ^ d,
                xtime(a) ^ a ^ b ^ c ^ xtime(d)};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_idx_q   <= '0;
            work_q      <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef AES_MIXCOL_BYPASS_EN
            bypass_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            work_q      <= work_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef AES_MIXCOL_BYPASS_EN
            bypass_q    <= bypass_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (col_idx_q == LAST_COL) state_d = DONE;
            DONE:    if (out_ready) state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == IDLE) || (state_q == DONE && out_ready);
        accept      = in_valid && in_ready;
        work_d      = work_q;
        col_idx_d   = col_idx_q;
        acc_d       = acc_q;
        out_d       = out_q;
`ifdef AES_MIXCOL_BYPASS_EN
        bypass_d    = bypass_q;
`endif
        if (accept) begin
            work_d    = state_in;
            col_idx_d = '0;
`ifdef AES_MIXCOL_BYPASS_EN
            bypass_d  = in_bypass;
`endif
        end
        if (state_q == BUSY) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if ((2'(c) & GRP_MASK) == col_idx_q) begin
`ifdef AES_MIXCOL_BYPASS_EN
                    acc_d[127-32*c -: 32] = bypass_q ? work_q[127-32*c -: 32]
                                                     : mix_col(work_q[127-32*c -: 32]);
`else
                    acc_d[127-32*c -: 32] = mix_col(work_q[127-32*c -: 32]);
`endif
                end
            end
            col_idx_d = col_idx_q + STEP;
            if (col_idx_q == LAST_COL) out_d = acc_d;
        end
        out_valid_d = (state_d == DONE);
        out_valid   = out_valid_q;
        state_out   = out_q;
    end

endmodule
